// File: rtl/vga_scan_timing.sv
// Raster scan timing: h/v counters, scan coordinates, undelayed strobes and
// hsync/vsync/de delayed by PIPE_DELAY pixel ticks to match the fetch pipeline.
module vga_scan_timing #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [9:0] posx,
    output logic [8:0] posy,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned RW       = 3;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          h_vis, v_vis;
    logic          raw_hs, raw_vs;
    logic [RW-1:0] raw_c;
    logic [RW-1:0] dly_c;

    // Counter advance; vertical steps on the same tick the line wraps.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (en) begin
            if (hcnt_q == CW'(H_TOTAL - 1)) begin
                hcnt_d = '0;
                if (vcnt_q == CW'(V_TOTAL - 1)) begin
                    vcnt_d = '0;
                end else begin
                    vcnt_d = vcnt_q + CW'(1);
                end
            end else begin
                hcnt_d = hcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    always_comb begin
        h_vis       = hcnt_q < CW'(H_ACTIVE);
        v_vis       = vcnt_q < CW'(V_ACTIVE);
        active      = h_vis && v_vis;
        posx        = h_vis ? hcnt_q : '0;
        posy        = v_vis ? vcnt_q[8:0] : '0;
        raw_hs      = (hcnt_q >= CW'(HS_START)) && (hcnt_q < CW'(HS_END));
        raw_vs      = (vcnt_q >= CW'(VS_START)) && (vcnt_q < CW'(VS_END));
        raw_c       = {raw_hs, raw_vs, active};
        line_start  = rst_n && en && (hcnt_q == '0);
        frame_start = line_start && (vcnt_q == '0);
    end

    // Delay line holds active-high raw flags; polarity is applied at the output.
    if (PIPE_DELAY == 0) begin : g_nodly
        assign dly_c = raw_c;
    end else begin : g_dly
        logic [RW-1:0] pipe_q [PIPE_DELAY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(PIPE_DELAY); i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (en) begin
                pipe_q[0] <= raw_c;
                for (int i = 1; i < int'(PIPE_DELAY); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign dly_c = pipe_q[PIPE_DELAY-1];
    end

    always_comb begin
        hsync = dly_c[2] ^ ~SYNC_POL;
        vsync = dly_c[1] ^ ~SYNC_POL;
        de    = dly_c[0];
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Randomized-enable bench for vga_scan_timing: three configurations compared each
// cycle against a model that derives every output from the tick count since reset.
module tb_vga_scan_timing;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ticks = 0;

    always #5 clk = ~clk;

    logic [9:0] px_a, px_b, px_c;
    logic [8:0] py_a, py_b, py_c;
    logic act_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic act_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic act_c, hs_c, vs_c, de_c, ls_c, fs_c;

    vga_scan_timing dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(px_a), .posy(py_a), .active(act_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_scan_timing #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b1), .PIPE_DELAY(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(px_b), .posy(py_b), .active(act_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_scan_timing #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(1'b0), .PIPE_DELAY(5)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .posx(px_c), .posy(py_c), .active(act_c),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .line_start(ls_c), .frame_start(fs_c)
    );

    // Expected {posx, posy, active, hsync, vsync, de, line_start, frame_start}
    // after n ticks since reset; delayed outputs are the decode of tick n-d.
    function automatic logic [24:0] model(input int ha, input int hf, input int hs,
                                          input int hb, input int va, input int vf,
                                          input int vs, input int vb, input int pol,
                                          input int d, input int n, input logic e,
                                          input logic r);
        int ht, vt, h, v, m, mh, mv;
        logic [9:0] ex;
        logic [8:0] ey;
        logic ea, eh, ev, ed, el, ef;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h  = n % ht;
        v  = (n / ht) % vt;
        ex = (h < ha) ? 10'(h) : 10'd0;
        ey = (v < va) ? 9'(v) : 9'd0;
        ea = (h < ha) && (v < va);
        el = e && r && (h == 0);
        ef = el && (v == 0);
        eh = 1'b0;
        ev = 1'b0;
        ed = 1'b0;
        if (n >= d) begin
            m  = n - d;
            mh = m % ht;
            mv = (m / ht) % vt;
            eh = (mh >= ha + hf) && (mh < ha + hf + hs);
            ev = (mv >= va + vf) && (mv < va + vf + vs);
            ed = (mh < ha) && (mv < va);
        end
        return {ex, ey, ea, (eh ? pol[0] : ~pol[0]), (ev ? pol[0] : ~pol[0]), ed, el, ef};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s tick=%0d got=%h exp=%h", tag, ticks, got, exp);
        end
    endtask

    task automatic check_all();
        check_val("cfg_a", 32'({px_a, py_a, act_a, hs_a, vs_a, de_a, ls_a, fs_a}),
                  32'(model(640, 16, 96, 48, 480, 10, 2, 33, 0, 2, ticks, en, rst_n)));
        check_val("cfg_b", 32'({px_b, py_b, act_b, hs_b, vs_b, de_b, ls_b, fs_b}),
                  32'(model(20, 3, 4, 5, 12, 2, 2, 3, 1, 0, ticks, en, rst_n)));
        check_val("cfg_c", 32'({px_c, py_c, act_c, hs_c, vs_c, de_c, ls_c, fs_c}),
                  32'(model(20, 3, 4, 5, 12, 2, 2, 3, 0, 5, ticks, en, rst_n)));
    endtask

    task automatic step(input logic e, input logic r);
        @(negedge clk);
        rst_n = r;
        en    = e;
        #1;
        check_all();
        if (e && r) ticks++;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        ticks = 0;
        check_all();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        // Continuous enable through line 0, the line wrap and into line 2.
        for (int i = 0; i < 1700; i++) step(1'b1, 1'b1);
        // One-in-four enable duty.
        for (int i = 0; i < 2400; i++) step(1'($urandom_range(0, 3) == 0), 1'b1);
        // Dense random enable.
        for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)), 1'b1);
        async_reset();
        for (int i = 0; i < 2500; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 2) != 0), 1'b1);
        async_reset();
        for (int i = 0; i < 900; i++) step(1'b1, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
# vga_scan_timing

Upstream raster timing stage for the graphics adapter. It generates the `posx`/`posy` scan coordinates consumed by the tile and bitmap pixel controllers, and the VGA `hsync`/`vsync`/`de` outputs. Sync and display-enable are delayed by a programmable number of pixel ticks so they line up with the pixel data leaving the fetch pipeline. It also emits line and frame strobes for register-update logic in the main module.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `SYNC_POL`, 0: sync active level (0 = active-low)
- `PIPE_DELAY`, 2: pixel ticks of delay applied to `hsync`/`vsync`/`de`; legal range 0..7

Ports:
- `clk`  in  1: system clock
- `rst_n`  in  1: asynchronous, active-low reset
- `en`  in  1: pixel tick enable; all state advances only when `en`=1
- `posx`  out  10: current column
- `posy`  out  9: current row
- `active`  out  1: undelayed visible-area flag
- `hsync`  out  1: delayed horizontal sync
- `vsync`  out  1: delayed vertical sync
- `de`  out  1: delayed display enable
- `line_start`  out  1: one-cycle strobe at column 0
- `frame_start`  out  1: one-cycle strobe at (0,0)

## Operation
- Counters:
  - `hcnt`: 10 bits, counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - `vcnt`: 10 bits, counts 0..V_TOTAL-1 (525).
- Per `en` tick:
  - `hcnt` increments.
  - At H_TOTAL-1, `hcnt` wraps to 0 and `vcnt` increments.
  - At V_TOTAL-1 with `hcnt`=H_TOTAL-1, `vcnt` wraps to 0.
- `posx` = `hcnt` if `hcnt` < H_ACTIVE, else 0.
- `posy` = `vcnt[8:0]` if `vcnt` < V_ACTIVE, else 0.
  - Holding 0 through blanking lets the downstream fetch pre-address tile row 0.
- `active` = (`hcnt` < H_ACTIVE) && (`vcnt` < V_ACTIVE).
- Raw hsync is active for `hcnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- Raw vsync is active for `vcnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491.
- Output levels:
  - Active level = SYNC_POL.
  - Inactive level = ~SYNC_POL.
- Delay line: raw {hsync, vsync, active} feed a PIPE_DELAY-deep shift register that shifts only on `en`.
  - PIPE_DELAY=0: outputs are a direct decode of the counters.
- `line_start` = `en` && (`hcnt`==0).
- `frame_start` = `en` && (`hcnt`==0) && (`vcnt`==0).
- Strobes are undelayed and aligned with `posx`/`posy`.
- `en`=0: counters, `posx`/`posy` and the delay line hold; both strobes are 0.

## Timing
- Reset (`rst_n`=0, asynchronous, at any point mid-frame):
  - `hcnt`=`vcnt`=0.
  - `posx`=0, `posy`=0.
  - Delay line cleared: `hsync`=`vsync`=~SYNC_POL, `de`=0.
  - `active`=1 (decoded from counters at 0,0).
  - Strobes 0.
- First `en` tick after reset release: `frame_start`=1 and `line_start`=1 in that cycle.
- Counter registers update on the `clk` edge where `en`=1.
- `posx`/`posy`/`active`/strobes are combinational from the registers; zero latency.
- `hsync`/`vsync`/`de` lag the counter state by exactly PIPE_DELAY `en` ticks.
  - Ticks are counted, not clocks, so alignment is preserved under any `en` duty cycle.
- Boundary conditions:
  - `hcnt` wrap and `vcnt` increment occur on the same tick.
  - Frame wrap at (524, 799) goes to (0, 0) in one tick.
  - The first PIPE_DELAY ticks after reset output the reset (inactive) levels.
- Line period: 800 ticks. Frame period: 420000 ticks.

## Test plan
- Reset then `en`=1 continuously, PIPE_DELAY=2 → `frame_start`=1 on tick 0 only. Raw hsync active ticks 656..751. `hsync`=0 on ticks 658..753, 1 elsewhere in line 0.
- Line wrap: tick 799 → `posx`=0, `posy`=1 on tick 800, `line_start`=1 on tick 800. `posx`=639 on tick 639, and `posx`=0 on tick 640 with `active`=0.
- Frame wrap: run 420000 ticks → `vsync`=0 for 1600 ticks, starting at tick 490·800+2. `frame_start` recurs at tick 420000. `posy`=0 throughout lines 480..524.
- `en` at 1-in-4 duty → every transition occurs at 4× the clock count. `hsync` stays exactly 2 ticks behind raw. Strobes are never asserted while `en`=0.
- Assert `rst_n` low asynchronously at line 300, column 100 → all outputs return to reset values with no clock. After release, the sequence restarts from (0,0) with `frame_start` on the first tick.
- PIPE_DELAY=0, SYNC_POL=1 → `hsync`=1 exactly on ticks 656..751 of each line. `de` equals `active`.
